sync_nd_filter: RTL and testbench

Parametrised multi-channel synchronizer for bringing asynchronous level signals into the `clk` domain. It has configurable flop depth, a per-bit reset value, an optional per-channel stability filter, and registered one-cycle rise/fall strobes. It sits at the edge of the MM AXI wrapper and replaces hand-instantiated 2- and 3-deep flop chains for status, interrupt and handshake levels arriving from other clock domains or from pins.

---
 rtl/sync_nd_filter.sv | 98 +++++++++
 tb/tb_sync_nd_filter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_nd_filter.sv
// Multi-channel level synchronizer: configurable flop depth, optional per-channel
// stability filter, and registered one-cycle rise/fall/change strobes.
module sync_nd_filter #(
  parameter int unsigned    DW      = 1,
  parameter int unsigned    STAGES  = 2,
  parameter int unsigned    FILT    = 0,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  output logic          chg
);

  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("sync_nd_filter: STAGES must be in 2..8");
  end
  if (FILT > 255) begin : g_bad_filt
    $error("sync_nd_filter: FILT must be in 0..255");
  end

  logic [DW-1:0] sync_q [STAGES];
  logic [DW-1:0] s;
  logic [DW-1:0] q_cur;
  logic [DW-1:0] q_d;
  logic [DW-1:0] rise_q;
  logic [DW-1:0] fall_q;
  logic          chg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= d;
      for (int unsigned k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[STAGES-1];

  if (FILT == 0) begin : g_nofilt
    // Without a filter the last sync stage is the output register, so its
    // next value is simply the stage feeding it.
    assign q_cur = s;
    assign q_d   = sync_q[STAGES-2];
  end else begin : g_filt
    localparam int unsigned CW = $clog2(FILT + 1);

    logic [DW-1:0] filt_q;
    logic [CW-1:0] cnt_q [DW];
    logic [CW-1:0] cnt_d [DW];

    always_comb begin
      q_d = filt_q;
      for (int unsigned i = 0; i < DW; i++) begin
        cnt_d[i] = '0;
        if (s[i] != filt_q[i]) begin
          if (cnt_q[i] == CW'(FILT - 1)) q_d[i] = s[i];
          else                           cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= RST_VAL;
        for (int unsigned i = 0; i < DW; i++) cnt_q[i] <= '0;
      end else begin
        filt_q <= q_d;
        for (int unsigned i = 0; i < DW; i++) cnt_q[i] <= cnt_d[i];
      end
    end

    assign q_cur = filt_q;
  end

  // Strobes are registered alongside q so they coincide with its first new cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      rise_q <= ~q_cur & q_d;
      fall_q <= q_cur & ~q_d;
      chg_q  <= |(q_cur ^ q_d);
    end
  end

  assign q    = q_cur;
  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = chg_q;

endmodule

// File: tb/tb_sync_nd_filter.sv
// Directed bench for sync_nd_filter covering several parameter configurations.
module tb_sync_nd_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: DW=1 STAGES=2 FILT=0
  logic       dA, qA, riseA, fallA, chgA;
  // B: DW=4 STAGES=3 FILT=0 RST_VAL=1010
  logic [3:0] dB, qB, riseB, fallB;
  logic       chgB;
  // C: DW=1 STAGES=2 FILT=4
  logic       dC, qC, riseC, fallC, chgC;
  // D: DW=1 STAGES=2 FILT=8
  logic       dD, qD, riseD, fallD, chgD;
  // E: DW=8 STAGES=8 FILT=0
  logic [7:0] dE, qE, riseE, fallE;
  logic       chgE;

  sync_nd_filter #(.DW(1), .STAGES(2), .FILT(0), .RST_VAL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .d(dA), .q(qA), .rise(riseA), .fall(fallA), .chg(chgA));
  sync_nd_filter #(.DW(4), .STAGES(3), .FILT(0), .RST_VAL(4'b1010)) u_b (
    .clk(clk), .rst_n(rst_n), .d(dB), .q(qB), .rise(riseB), .fall(fallB), .chg(chgB));
  sync_nd_filter #(.DW(1), .STAGES(2), .FILT(4), .RST_VAL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .d(dC), .q(qC), .rise(riseC), .fall(fallC), .chg(chgC));
  sync_nd_filter #(.DW(1), .STAGES(2), .FILT(8), .RST_VAL(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .d(dD), .q(qD), .rise(riseD), .fall(fallD), .chg(chgD));
  sync_nd_filter #(.DW(8), .STAGES(8), .FILT(0), .RST_VAL(8'h00)) u_e (
    .clk(clk), .rst_n(rst_n), .d(dE), .q(qE), .rise(riseE), .fall(fallE), .chg(chgE));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    dA = 1'b0; dB = 4'b1010; dC = 1'b0; dD = 1'b0; dE = 8'h00;
    rst_n = 1'b0;
    step();
    n_checks++;
    if (qA !== 1'b0) begin n_fail++; $display("FAIL reset_qA got %b want 0", qA); end
    n_checks++;
    if (qB !== 4'b1010) begin n_fail++; $display("FAIL reset_qB got %b want 1010", qB); end
    n_checks++;
    if (qC !== 1'b0 || riseC !== 1'b0 || fallC !== 1'b0) begin
      n_fail++; $display("FAIL reset_C q=%b rise=%b fall=%b want 0 0 0", qC, riseC, fallC);
    end
    n_checks++;
    if (chgA !== 1'b0 || chgB !== 1'b0 || chgE !== 1'b0) begin
      n_fail++; $display("FAIL reset_chg got %b%b%b want 000", chgA, chgB, chgE);
    end
    n_checks++;
    if (qE !== 8'h00) begin n_fail++; $display("FAIL reset_qE got %h want 00", qE); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_edges();
    dA = 1'b0;
    do_reset();
    step(); step();
    n_checks++;
    if (qA !== 1'b0) begin n_fail++; $display("FAIL basic_idle q got %b want 0", qA); end
    dA = 1'b1;
    step();
    n_checks++;
    if (qA !== 1'b0 || riseA !== 1'b0) begin
      n_fail++; $display("FAIL basic_edge1 q=%b rise=%b want 0 0", qA, riseA);
    end
    step();
    n_checks++;
    if (qA !== 1'b1 || riseA !== 1'b1 || chgA !== 1'b1 || fallA !== 1'b0) begin
      n_fail++; $display("FAIL basic_rise q=%b rise=%b fall=%b chg=%b want 1 1 0 1", qA, riseA, fallA, chgA);
    end
    step();
    n_checks++;
    if (qA !== 1'b1 || riseA !== 1'b0 || chgA !== 1'b0) begin
      n_fail++; $display("FAIL basic_rise_end q=%b rise=%b chg=%b want 1 0 0", qA, riseA, chgA);
    end
    dA = 1'b0;
    step();
    n_checks++;
    if (qA !== 1'b1 || fallA !== 1'b0) begin
      n_fail++; $display("FAIL basic_fall_early q=%b fall=%b want 1 0", qA, fallA);
    end
    step();
    n_checks++;
    if (qA !== 1'b0 || fallA !== 1'b1 || riseA !== 1'b0 || chgA !== 1'b1) begin
      n_fail++; $display("FAIL basic_fall q=%b rise=%b fall=%b chg=%b want 0 0 1 1", qA, riseA, fallA, chgA);
    end
    step();
    n_checks++;
    if (fallA !== 1'b0 || chgA !== 1'b0) begin
      n_fail++; $display("FAIL basic_fall_end fall=%b chg=%b want 0 0", fallA, chgA);
    end
  endtask

  task automatic test_reset_value();
    dB = 4'b1010;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (qB !== 4'b1010 || riseB !== 4'b0000 || fallB !== 4'b0000 || chgB !== 1'b0) begin
        n_fail++;
        $display("FAIL rstval_quiet cyc=%0d q=%b rise=%b fall=%b chg=%b want 1010 0000 0000 0",
                 i, qB, riseB, fallB, chgB);
      end
    end
    dB = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (k < 3) begin
        if (qB !== 4'b1010 || chgB !== 1'b0) begin
          n_fail++; $display("FAIL rstval_early k=%0d q=%b chg=%b want 1010 0", k, qB, chgB);
        end
      end else if (k == 3) begin
        if (qB !== 4'b0101 || riseB !== 4'b0101 || fallB !== 4'b1010 || chgB !== 1'b1) begin
          n_fail++;
          $display("FAIL rstval_multi q=%b rise=%b fall=%b chg=%b want 0101 0101 1010 1",
                   qB, riseB, fallB, chgB);
        end
      end else begin
        if (qB !== 4'b0101 || riseB !== 4'b0000 || fallB !== 4'b0000 || chgB !== 1'b0) begin
          n_fail++;
          $display("FAIL rstval_after q=%b rise=%b fall=%b chg=%b want 0101 0000 0000 0",
                   qB, riseB, fallB, chgB);
        end
      end
    end
  endtask

  task automatic test_filter_reject();
    dC = 1'b0;
    do_reset();
    step(); step(); step();
    dC = 1'b1;
    step(); step(); step();
    dC = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (qC !== 1'b0 || riseC !== 1'b0 || chgC !== 1'b0) begin
        n_fail++; $display("FAIL filt_reject cyc=%0d q=%b rise=%b chg=%b want 0 0 0", i, qC, riseC, chgC);
      end
    end
  endtask

  task automatic test_filter_accept();
    logic eq, er, ef;
    dC = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) dC = 1'b0;
      eq = (k >= 6 && k <= 9);
      er = (k == 6);
      ef = (k == 10);
      n_checks++;
      if (qC !== eq || riseC !== er || fallC !== ef) begin
        n_fail++;
        $display("FAIL filt_accept k=%0d q=%b rise=%b fall=%b want %b %b %b",
                 k, qC, riseC, fallC, eq, er, ef);
      end
    end
  endtask

  task automatic test_filter_toggle();
    dD = 1'b0;
    do_reset();
    step();
    for (int c = 0; c < 100; c++) begin
      if (c % 3 == 0) dD = ~dD;
      step();
      n_checks++;
      if (qD !== 1'b0 || riseD !== 1'b0 || fallD !== 1'b0 || chgD !== 1'b0) begin
        n_fail++;
        $display("FAIL filt_toggle cyc=%0d q=%b rise=%b fall=%b chg=%b want 0 0 0 0",
                 c, qD, riseD, fallD, chgD);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    dC = 1'b0;
    do_reset();
    step(); step();
    dC = 1'b1;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (qC !== 1'b0 || riseC !== 1'b0 || chgC !== 1'b0) begin
      n_fail++; $display("FAIL midrst_assert q=%b rise=%b chg=%b want 0 0 0", qC, riseC, chgC);
    end
    step();
    rst_n = 1'b1;
    rises = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (riseC === 1'b1) rises++;
      n_checks++;
      if (qC !== (k >= 6) || riseC !== (k == 6)) begin
        n_fail++;
        $display("FAIL midrst_relatch k=%0d q=%b rise=%b want %b %b", k, qC, riseC, (k >= 6), (k == 6));
      end
    end
    n_checks++;
    if (rises != 1) begin n_fail++; $display("FAIL midrst_rise_count got %0d want 1", rises); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pipe [8];
    logic [7:0] dsamp, expq, prevq;
    int hold;
    dE = 8'h00;
    do_reset();
    for (int i = 0; i < 8; i++) pipe[i] = 8'h00;
    prevq = 8'h00;
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold == 0) begin
        dE = 8'($urandom());
        hold = $urandom_range(2, 4);
      end
      hold--;
      dsamp = dE;
      step();
      for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = dsamp;
      expq = pipe[7];
      n_checks++;
      if (qE !== expq) begin n_fail++; $display("FAIL b2b_q cyc=%0d got %h want %h", c, qE, expq); end
      n_checks++;
      if (riseE !== (~prevq & expq) || fallE !== (prevq & ~expq)) begin
        n_fail++;
        $display("FAIL b2b_strobe cyc=%0d rise=%h fall=%h want %h %h", c, riseE, fallE,
                 (~prevq & expq), (prevq & ~expq));
      end
      n_checks++;
      if (chgE !== (prevq != expq)) begin
        n_fail++; $display("FAIL b2b_chg cyc=%0d got %b want %b", c, chgE, (prevq != expq));
      end
      prevq = expq;
    end
  endtask

  initial begin
    test_reset();
    test_basic_edges();
    test_reset_value();
    test_filter_reject();
    test_filter_accept();
    test_filter_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
